hidden_layer_ctrl: RTL and testbench

Sequencer for the drowsiness-detector hidden layer: on `start` it captures the 10 input features, then walks one shared signed multiply-accumulate unit over every neuron's weight row and bias in an external synchronous weight RAM. It applies a step activation per neuron and returns the 5-bit hidden-layer output vector. Between runs it owns the RAM write port, so host weight loading and inference share one memory through this block.

---
 rtl/nn_pkg.sv | 35 +++
 rtl/mac_unit.sv | 42 ++++
 rtl/hidden_layer_ctrl.sv | 134 +++++++++++++
 tb/tb_hidden_layer_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// ============================================================================
// nn_pkg : shared constants, state encoding and weight-RAM address helper
//          for the drowsiness-detector hidden layer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package nn_pkg;
    localparam int N_IN  = 10;
    localparam int N_HID = 5;
    localparam int DW    = 10;
    localparam int ACCW  = 26;
    localparam int AW    = 6;
    localparam int ROW   = N_IN + 1;

    localparam int EW = $clog2(ROW);
    localparam int NW = $clog2(N_HID);

    localparam logic [EW-1:0] BIAS_ELEM   = EW'(N_IN);
    localparam logic [NW-1:0] LAST_NEURON = NW'(N_HID - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Element N_IN of a row is the neuron's bias.
    function automatic logic [AW-1:0] row_addr(input logic [NW-1:0] neuron,
                                               input logic [EW-1:0] elem);
        return AW'(int'(neuron) * ROW + int'(elem));
    endfunction
endpackage

`default_nettype wire

// File: rtl/mac_unit.sv
// ============================================================================
// mac_unit : signed weight x unsigned feature multiply-accumulate with a
//            bias-add output that retires the accumulated neuron.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_unit
    import nn_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   add_bias,
    input  logic [DW-1:0]          weight,
    input  logic [DW-1:0]          x,
    output logic signed [ACCW-1:0] bias_sum
);
    logic signed [ACCW-1:0] r_acc;
    logic signed [2*DW:0]   w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_bias_ext;

    // Feature is zero-extended so it stays non-negative in the signed product.
    assign w_prod     = $signed(weight) * $signed({1'b0, x});
    assign w_prod_ext = {{(ACCW-2*DW-1){w_prod[2*DW]}}, w_prod};
    assign w_bias_ext = {{(ACCW-DW){weight[DW-1]}}, weight};
    assign bias_sum   = r_acc + w_bias_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clear || (enable && add_bias)) begin
            r_acc <= '0;
        end else if (enable) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end
endmodule

`default_nettype wire

// File: rtl/hidden_layer_ctrl.sv
// ============================================================================
// hidden_layer_ctrl : sequences the shared MAC over all weight rows in the
//                     external RAM and owns the RAM write port between runs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hidden_layer_ctrl
    import nn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_IN*DW-1:0]   in_val,
    output logic                 busy,
    output logic                 done,
    output logic [N_HID-1:0]     out_val,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [DW-1:0]        cfg_wdata,
    output logic                 cfg_ready,
    output logic                 w_we,
    output logic [AW-1:0]        w_addr,
    output logic [DW-1:0]        w_wdata,
    input  logic [DW-1:0]        w_rdata
);
    state_t                 r_state, w_next_state;
    logic [DW-1:0]          r_feat [N_IN];
    logic [NW-1:0]          r_neuron;
    logic [EW-1:0]          r_elem;
    logic                   r_cons_valid;
    logic [NW-1:0]          r_cons_neuron;
    logic [EW-1:0]          r_cons_elem;
    logic [N_HID-1:0]       r_shadow, w_shadow_next;
    logic                   r_done;
    logic [N_HID-1:0]       r_out_val;
    logic                   w_start_ok;
    logic                   w_is_bias;
    logic [DW-1:0]          w_x;
    logic signed [ACCW-1:0] w_bias_sum;

    assign done    = r_done;
    assign out_val = r_out_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        cfg_ready    = 1'b0;
        w_we         = 1'b0;
        w_addr       = row_addr(r_neuron, r_elem);
        w_wdata      = cfg_wdata;
        w_start_ok   = 1'b0;
        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                cfg_ready = 1'b1;
                w_we      = cfg_we;
                w_addr    = cfg_addr;
                if (start) begin
                    w_start_ok   = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (r_neuron == LAST_NEURON && r_elem == BIAS_ELEM)
                    w_next_state = DRAIN;
            end
            // The final bias returns during the single DRAIN cycle.
            DRAIN:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_is_bias = (r_cons_elem == BIAS_ELEM);
    assign w_x       = w_is_bias ? '0 : r_feat[r_cons_elem];

    mac_unit u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_start_ok),
        .enable   (r_cons_valid),
        .add_bias (w_is_bias),
        .weight   (w_rdata),
        .x        (w_x),
        .bias_sum (w_bias_sum)
    );

    always_comb begin
        w_shadow_next = r_shadow;
        if (r_cons_valid && w_is_bias)
            w_shadow_next[r_cons_neuron] = (w_bias_sum > 0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) r_feat[i] <= '0;
            r_neuron      <= '0;
            r_elem        <= '0;
            r_cons_valid  <= 1'b0;
            r_cons_neuron <= '0;
            r_cons_elem   <= '0;
            r_shadow      <= '0;
            r_done        <= 1'b0;
            r_out_val     <= '0;
        end else begin
            r_cons_valid  <= (r_state == RUN);
            r_cons_neuron <= r_neuron;
            r_cons_elem   <= r_elem;
            r_shadow      <= w_shadow_next;
            r_done        <= (r_state == DRAIN);
            if (r_state == DRAIN) r_out_val <= w_shadow_next;

            if (w_start_ok) begin
                for (int i = 0; i < N_IN; i++) r_feat[i] <= in_val[i*DW +: DW];
                r_neuron <= '0;
                r_elem   <= '0;
            end else if (r_state == RUN) begin
                if (r_elem == BIAS_ELEM) begin
                    r_elem   <= '0;
                    r_neuron <= r_neuron + 1'b1;
                end else begin
                    r_elem <= r_elem + 1'b1;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_hidden_layer_ctrl.sv
// ============================================================================
// tb_hidden_layer_ctrl : scoreboard bench with a synchronous RAM model and an
//                        arithmetic reference of the hidden layer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hidden_layer_ctrl;
    import nn_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [N_IN*DW-1:0]   in_val = '0;
    logic                 busy, done, cfg_ready, w_we;
    logic [N_HID-1:0]     out_val;
    logic                 cfg_we = 1'b0;
    logic [AW-1:0]        cfg_addr = '0;
    logic [DW-1:0]        cfg_wdata = '0;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_wdata;
    logic [DW-1:0]        w_rdata;

    logic [DW-1:0] ram     [64];
    logic [DW-1:0] model_w [64];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [N_HID-1:0] val;
        int               cyc;
    } exp_t;
    exp_t q[$];

    hidden_layer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_val(in_val),
        .busy(busy), .done(done), .out_val(out_val),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_ready(cfg_ready), .w_we(w_we), .w_addr(w_addr),
        .w_wdata(w_wdata), .w_rdata(w_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_we) ram[w_addr] <= w_wdata;
        w_rdata <= ram[w_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: signed dot product plus bias, positive sum fires.
    function automatic logic [N_HID-1:0] ref_out(input logic [N_IN*DW-1:0] x);
        logic [N_HID-1:0] r;
        longint s;
        r = '0;
        for (int n = 0; n < N_HID; n++) begin
            s = 0;
            for (int i = 0; i < N_IN; i++)
                s += longint'($signed(model_w[n*ROW+i])) * longint'(x[i*DW +: DW]);
            s += longint'($signed(model_w[n*ROW+N_IN]));
            r[n] = (s > 0);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_val", 32'(out_val), 32'(e.val));
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic host_write(input int a, input logic [DW-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_wdata = d;
        model_w[a] = d;
        tick();
        cfg_we   = 1'b0;
        cfg_addr = '0;
    endtask

    function automatic logic [N_IN*DW-1:0] feat_all(input logic [DW-1:0] v);
        logic [N_IN*DW-1:0] x;
        for (int i = 0; i < N_IN; i++) x[i*DW +: DW] = v;
        return x;
    endfunction

    function automatic logic [N_IN*DW-1:0] feat_rand();
        logic [N_IN*DW-1:0] x;
        for (int i = 0; i < N_IN; i++) x[i*DW +: DW] = DW'($urandom);
        return x;
    endfunction

    // Issues start in the current cycle (t0); returns in t0+1 with input scrambled.
    task automatic start_run(input logic [N_IN*DW-1:0] x, output int t0);
        t0     = cyc;
        in_val = x;
        start  = 1'b1;
        q.push_back('{ref_out(x), t0 + 57});
        tick();
        start  = 1'b0;
        in_val = feat_rand();
        check("busy_rise", 32'(busy), 32'd1);
        check("first_addr", 32'(w_addr), 32'd0);
    endtask

    task automatic run(input logic [N_IN*DW-1:0] x);
        int t0;
        start_run(x, t0);
        wait_to(t0 + 56);
        check("busy_last", 32'(busy), 32'd1);
        wait_to(t0 + 57);
    endtask

    initial begin
        int t0;
        for (int i = 0; i < 64; i++) model_w[i] = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_val", 32'(out_val), 32'd0);
        check("rst_w_we", 32'(w_we), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        // All weights 1, biases 0, inputs 1
        for (int a = 0; a < N_HID*ROW; a++)
            host_write(a, (a % ROW == N_IN) ? DW'(0) : DW'(1));
        run(feat_all(DW'(1)));

        // Neuron 2 sums exactly to 0, neuron 4 goes negative
        host_write(2*ROW + N_IN, DW'(-10));
        host_write(4*ROW + N_IN, DW'(-11));
        run(feat_all(DW'(1)));

        // Magnitude extremes
        for (int a = 0; a < N_HID*ROW; a++) begin
            if (a < ROW)        host_write(a, (a == N_IN) ? DW'(0) : DW'(511));
            else if (a < 2*ROW) host_write(a, (a == ROW + N_IN) ? DW'(511) : DW'(-512));
            else                host_write(a, DW'(0));
        end
        run(feat_all(DW'(1023)));

        // Host write and repeat start during a run are both dropped
        start_run(feat_all(DW'(1023)), t0);
        wait_to(t0 + 10);
        cfg_we = 1'b1; cfg_addr = AW'(3); cfg_wdata = DW'(-512);
        #1;
        check("busy_write_blocked", 32'(w_we), 32'd0);
        check("busy_cfg_ready", 32'(cfg_ready), 32'd0);
        tick();
        cfg_we = 1'b0; cfg_addr = '0;
        wait_to(t0 + 20);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_to(t0 + 57);
        run(feat_all(DW'(1023)));

        // Start and host write in the same IDLE cycle
        for (int a = 0; a < N_HID*ROW; a++) host_write(a, DW'(0));
        host_write(N_IN, DW'(-1));
        cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = DW'(2);
        model_w[0] = DW'(2);
        start_run(feat_all(DW'(1)), t0);
        cfg_we = 1'b0;
        wait_to(t0 + 57);

        // Abort with reset mid-run, then a fresh run
        start_run(feat_rand(), t0);
        wait_to(t0 + 20);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out_val", 32'(out_val), 32'd0);
        q.delete();
        tick(); tick();
        rst_n = 1'b1;
        wait_to(t0 + 60);
        check("abort_no_done", 32'(done), 32'd0);
        run(feat_all(DW'(1)));

        // Randomised weights, back-to-back runs
        for (int k = 0; k < 6; k++) begin
            for (int a = 0; a < N_HID*ROW; a++)
                host_write(a, (k < 3) ? DW'($urandom) : DW'($urandom_range(0, 40) - 20));
            run(feat_rand());
            run(feat_rand());
        end

        for (int w = 0; w < 100 && q.size() != 0; w++) tick();
        if (q.size() != 0) check("done_timeout", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
